// File: rtl/vga_timing_pkg.sv
// Shared VGA scan timing: default 640x480@60 constants, derived totals and
// sync window bounds, the controller state encoding, and a range helper.
package vga_timing_pkg;

  // Horizontal timing, in pixels
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_HS_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC - 1;

  // Vertical timing, in lines
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int VGA_VS_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC - 1;

  // System clocks per pixel tick (must be >= 1)
  localparam int VGA_PIX_DIV  = 4;

  // Scan controller states
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Inclusive range test on a 10-bit counter value
  function automatic logic in_range(input logic [9:0] x,
                                    input logic [9:0] lo,
                                    input logic [9:0] hi);
    return (x >= lo) && (x <= hi);
  endfunction

endpackage

// File: rtl/vga_pix_div.sv
// Pixel clock-enable generator: div counts 0..PIX_DIV-1 while run is high,
// is held at 0 otherwise, and tick marks the last count of each pixel.
module vga_pix_div
  import vga_timing_pkg::*;
#(
  parameter int PIX_DIV = VGA_PIX_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);

  logic [DW-1:0] div;

  // Divider counter: cleared by reset or when not scanning, wraps at DIV_LAST
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      div <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + DW'(1);
    end
  end

  assign tick = run && (div == DIV_LAST);

endmodule

// File: rtl/vga_sync_ctrl.sv
// VGA scan timing controller: IDLE/RUN FSM, h/v pixel counters, registered
// sync/video decode and line/frame strobes.
// Build option: define VGA_PIX_DIV_EN to advance pixels every VGA_PIX_DIV
// clocks via vga_pix_div; otherwise every RUN cycle is a pixel tick.
// The busy output is the FSM state (high in RUN).
// H/V totals must not exceed 1024 so the 10-bit counters never overflow.
module vga_sync_ctrl
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       busy,
  output logic [9:0] h_count,
  output logic [9:0] v_count,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       line_end,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  state_t     state, state_n;
  logic       en_q;
  logic       tick;
  logic [9:0] h_n, v_n;
  logic       hsync_n, vsync_n, video_on_n, line_end_n, frame_start_n;

`ifdef VGA_PIX_DIV_EN
  vga_pix_div #(
    .PIX_DIV (VGA_PIX_DIV)
  ) u_pix_div (
    .clk  (clk),
    .rst  (rst),
    .run  (state == RUN),
    .tick (tick)
  );
`else
  assign tick = (state == RUN);
`endif

  assign busy = (state == RUN);

  // Next state, next counters and strobes; a running frame only stops on its
  // final tick, and only when en is low at that edge
  always_comb begin
    state_n       = state;
    h_n           = h_count;
    v_n           = v_count;
    line_end_n    = 1'b0;
    frame_start_n = 1'b0;
    case (state)
      IDLE: begin
        h_n = '0;
        v_n = '0;
        if (en_q) begin
          state_n       = RUN;
          frame_start_n = 1'b1;
        end
      end
      RUN: begin
        if (tick) begin
          if (h_count == H_LAST) begin
            h_n = '0;
            if (v_count == V_LAST) begin
              v_n = '0;
              if (en) begin
                line_end_n    = 1'b1;
                frame_start_n = 1'b1;
              end else begin
                state_n = IDLE;
              end
            end else begin
              v_n        = v_count + 10'd1;
              line_end_n = 1'b1;
            end
          end else begin
            h_n = h_count + 10'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Sync and video decode from the next counter values so they line up with
  // the counters registered on the same edge
  always_comb begin
    hsync_n    = !in_range(h_n, HS_START, HS_END);
    vsync_n    = !in_range(v_n, VS_START, VS_END);
    video_on_n = (state_n == RUN) && (h_n < H_ACT) && (v_n < V_ACT);
  end

  // State, counter and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      en_q        <= 1'b0;
      h_count     <= '0;
      v_count     <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      line_end    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_n;
      en_q        <= en;
      h_count     <= h_n;
      v_count     <= v_n;
      hsync       <= hsync_n;
      vsync       <= vsync_n;
      video_on    <= video_on_n;
      line_end    <= line_end_n;
      frame_start <= frame_start_n;
    end
  end

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// Bench for vga_sync_ctrl using a reduced timing geometry so whole frames fit
// in a short run. The reference model tracks only "running?" and the clock
// count since the frame started; every output is derived from that count with
// plain division and modulo.
module tb_vga_sync_ctrl;

  localparam int HA = 16, HF = 4, HS = 6, HB = 6;
  localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;   // 32
  localparam int VT = VA + VF + VS + VB;   // 15
`ifdef VGA_PIX_DIV_EN
  localparam int PD = 4;
`else
  localparam int PD = 1;
`endif
  localparam int LINE = HT * PD;
  localparam int FR   = HT * VT * PD;
  localparam logic [25:0] RESET_VEC = {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       busy, hsync, vsync, video_on, line_end, frame_start;
  logic [9:0] h_count, v_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  vga_sync_ctrl #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .busy        (busy),
    .h_count     (h_count),
    .v_count     (v_count),
    .hsync       (hsync),
    .vsync       (vsync),
    .video_on    (video_on),
    .line_end    (line_end),
    .frame_start (frame_start)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wire [25:0] obs = {busy, h_count, v_count, hsync, vsync, video_on, line_end, frame_start};

  // Reference model: run flag, clocks since frame start, entry marker
  logic m_busy, m_fresh, m_en_prev;
  int   m_k;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_fresh <= 1'b0; m_en_prev <= 1'b0; m_k <= 0;
    end else begin
      m_en_prev <= en;
      m_fresh   <= 1'b0;
      if (!m_busy) begin
        if (m_en_prev) begin
          m_busy <= 1'b1; m_k <= 0; m_fresh <= 1'b1;
        end
      end else if (m_k == FR - 1) begin
        m_k <= 0;
        if (!en) m_busy <= 1'b0;
      end else begin
        m_k <= m_k + 1;
      end
    end
  end

  int          e_pix, e_h, e_v;
  logic [25:0] exp_vec;

  // Expected outputs computed from the model's position in the frame
  always_comb begin
    e_pix   = m_k / PD;
    e_h     = e_pix % HT;
    e_v     = e_pix / HT;
    exp_vec = RESET_VEC;
    if (m_busy) begin
      exp_vec = {1'b1, 10'(e_h), 10'(e_v),
                 !((e_h >= HA + HF) && (e_h < HA + HF + HS)),
                 !((e_v >= VA + VF) && (e_v < VA + VF + VS)),
                 (e_h < HA) && (e_v < VA),
                 ((m_k % LINE) == 0) && !m_fresh,
                 (m_k == 0)};
    end
  end

  task automatic test_reset();
    rst = 1'b1; en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (obs !== RESET_VEC) begin
        failures++; $display("FAIL reset_hold cyc=%0d obs=%h exp=%h", cyc, obs, RESET_VEC);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== RESET_VEC) begin
      failures++; $display("FAIL start_gap cyc=%0d obs=%h exp=%h", cyc, obs, RESET_VEC);
    end
    @(negedge clk);
    checks++;
    if ({busy, frame_start, line_end, video_on, h_count, v_count} !== {4'b1101, 10'd0, 10'd0}) begin
      failures++; $display("FAIL start_entry cyc=%0d obs=%h", cyc, obs);
    end
    for (int i = 1; i <= PD; i++) begin
      @(negedge clk);
      checks++;
      if (h_count !== ((i == PD) ? 10'd1 : 10'd0) || frame_start !== 1'b0) begin
        failures++; $display("FAIL start_hstep i=%0d h=%0d fs=%b", i, h_count, frame_start);
      end
    end
  endtask

  task automatic test_horizontal();
    int  hs_low, vid, t;
    logic prev_hs, exp_vis;
    en = 1'b1;
    t = 0;
    while (line_end !== 1'b1 && t < 2 * LINE) begin
      @(negedge clk); t++;
    end
    checks++;
    if (line_end !== 1'b1) begin
      failures++; $display("FAIL h_wait_line_end got=%b want=1", line_end);
    end
    for (int ln = 0; ln < 2; ln++) begin
      hs_low = 0; vid = 0; prev_hs = 1'b1;
      exp_vis = (e_v < VA);
      for (int i = 0; i < LINE; i++) begin
        checks++;
        if (obs !== exp_vec) begin
          failures++; $display("FAIL h_model cyc=%0d obs=%h exp=%h", cyc, obs, exp_vec);
        end
        if (prev_hs && !hsync) begin
          checks++;
          if (h_count !== 10'(HA + HF)) begin
            failures++; $display("FAIL hsync_start h=%0d want=%0d", h_count, HA + HF);
          end
        end
        prev_hs = hsync;
        if (!hsync) hs_low++;
        if (video_on) vid++;
        @(negedge clk);
      end
      checks++;
      if (hs_low !== HS * PD) begin
        failures++; $display("FAIL hsync_width got=%0d want=%0d", hs_low, HS * PD);
      end
      checks++;
      if (vid !== (exp_vis ? HA * PD : 0)) begin
        failures++; $display("FAIL video_line got=%0d want=%0d", vid, exp_vis ? HA * PD : 0);
      end
      checks++;
      if (line_end !== 1'b1 || h_count !== 10'd0) begin
        failures++; $display("FAIL line_period le=%b h=%0d want le=1 h=0", line_end, h_count);
      end
    end
  endtask

  task automatic test_vertical();
    int vs_low, vid, fs_cnt, t;
    en = 1'b1;
    t = 0;
    while (frame_start !== 1'b1 && t < FR + 8) begin
      @(negedge clk); t++;
    end
    checks++;
    if (frame_start !== 1'b1) begin
      failures++; $display("FAIL v_wait_frame_start got=%b want=1", frame_start);
    end
    vs_low = 0; vid = 0; fs_cnt = 0;
    for (int i = 0; i < FR; i++) begin
      checks++;
      if (obs !== exp_vec) begin
        failures++; $display("FAIL v_model cyc=%0d obs=%h exp=%h", cyc, obs, exp_vec);
      end
      if (!vsync) begin
        vs_low++;
        checks++;
        if (v_count < 10'(VA + VF) || v_count > 10'(VA + VF + VS - 1)) begin
          failures++; $display("FAIL vsync_line v=%0d", v_count);
        end
      end
      if (video_on) vid++;
      if (frame_start) fs_cnt++;
      @(negedge clk);
    end
    checks++;
    if (vs_low !== VS * HT * PD) begin
      failures++; $display("FAIL vsync_width got=%0d want=%0d", vs_low, VS * HT * PD);
    end
    checks++;
    if (vid !== HA * VA * PD) begin
      failures++; $display("FAIL video_frame got=%0d want=%0d", vid, HA * VA * PD);
    end
    checks++;
    if (fs_cnt !== 1 || frame_start !== 1'b1) begin
      failures++; $display("FAIL frame_period cnt=%0d fs_now=%b want 1/1", fs_cnt, frame_start);
    end
  endtask

  task automatic test_graceful_stop();
    int t;
    logic [9:0] ph, pv;
    logic found;
    en = 1'b1;
    t = 0;
    while (!(busy === 1'b1 && h_count == 10'd10 && v_count == 10'd5) && t < FR + 8) begin
      @(negedge clk); t++;
    end
    checks++;
    if (!(h_count == 10'd10 && v_count == 10'd5)) begin
      failures++; $display("FAIL stop_wait_pos h=%0d v=%0d want 10/5", h_count, v_count);
    end
    en = 1'b0;
    found = 1'b0; ph = h_count; pv = v_count;
    for (int i = 0; i < FR && !found; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec) begin
        failures++; $display("FAIL stop_model cyc=%0d obs=%h exp=%h", cyc, obs, exp_vec);
      end
      if (busy === 1'b0) found = 1'b1;
      else begin ph = h_count; pv = v_count; end
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL stop_timeout busy=%b want=0", busy);
    end
    checks++;
    if (ph !== 10'(HT - 1) || pv !== 10'(VT - 1)) begin
      failures++; $display("FAIL stop_last_pos h=%0d v=%0d want %0d/%0d", ph, pv, HT - 1, VT - 1);
    end
    checks++;
    if (obs !== RESET_VEC) begin
      failures++; $display("FAIL stop_idle obs=%h exp=%h", obs, RESET_VEC);
    end
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (obs !== RESET_VEC) begin
        failures++; $display("FAIL stop_stays_idle obs=%h exp=%h", obs, RESET_VEC);
      end
    end
  endtask

  task automatic test_back_to_back();
    en = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL restart_gap busy=%b want=0", busy);
    end
    @(negedge clk);
    checks++;
    if ({busy, frame_start, h_count, v_count} !== {2'b11, 10'd0, 10'd0}) begin
      failures++; $display("FAIL restart_entry obs=%h", obs);
    end
  endtask

  task automatic test_random_en();
    for (int i = 0; i < 4 * FR; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec) begin
        failures++; $display("FAIL rand_model cyc=%0d obs=%h exp=%h", cyc, obs, exp_vec);
      end
      if ($urandom_range(0, 31) == 0) en = ~en;
    end
  endtask

  task automatic test_reset_mid();
    int t;
    en = 1'b1;
    t = 0;
    while (!(busy === 1'b1 && h_count == 10'd20 && v_count == 10'd7) && t < 2 * FR + 8) begin
      @(negedge clk); t++;
    end
    checks++;
    if (!(h_count == 10'd20 && v_count == 10'd7)) begin
      failures++; $display("FAIL rmid_wait_pos h=%0d v=%0d want 20/7", h_count, v_count);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== RESET_VEC) begin
      failures++; $display("FAIL rmid_reset obs=%h exp=%h", obs, RESET_VEC);
    end
    rst = 1'b0;
    for (int i = 0; i < 3 * LINE; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec) begin
        failures++; $display("FAIL rmid_model cyc=%0d obs=%h exp=%h", cyc, obs, exp_vec);
      end
      if (i == 1) begin
        checks++;
        if ({busy, frame_start, h_count, v_count} !== {2'b11, 10'd0, 10'd0}) begin
          failures++; $display("FAIL rmid_restart obs=%h", obs);
        end
      end
    end
  endtask

  // Test sequence and summary
  initial begin
    rst = 1'b1;
    en  = 1'b0;
    test_reset();
    test_horizontal();
    test_vertical();
    test_graceful_stop();
    test_back_to_back();
    test_random_en();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
